uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART transmitter (tx_en/data/Load_Value in, done/busy out) between NUM_REQ byte requesters. It grants one requester at a time and latches that requester's byte. It drives the transmitter's level-style tx_en until done, then enforces an inter-frame gap. It also owns the baud-divisor register and a frame watchdog that resets the transmitter on a hang. It sits between the APB register/FIFO side and the UART TX core.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
DIV_W, 10, baud divisor width (matches the transmitter's Load_Value)
DEFAULT_DIV, 650, divisor value after reset
GAP_CYC, 4, idle clocks forced between frames (>=1)
TO_W, 16, watchdog counter width; the timeout fires at 2^TO_W-1 clocks in SEND

Ports:
clk  in  1  system clock, rising edge
arst  in  1  asynchronous reset, active-high
req  in  NUM_REQ  per-requester level request; hold until matching ack
req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]; stable while req[i]=1
ack  out  NUM_REQ  one-cycle pulse: requester's frame finished (or aborted)
cfg_div  in  DIV_W  new baud divisor
cfg_div_we  in  1  one-cycle write strobe for cfg_div
err_clr  in  1  clears timeout_err
tx_en  out  1  to transmitter tx_en
tx_data  out  DATA_W  to transmitter data (registered)
tx_load_value  out  DIV_W  to transmitter Load_Value (registered)
tx_rst  out  1  to transmitter synchronous rst, one-cycle pulse on timeout
tx_done  in  1  transmitter done
tx_busy  in  1  transmitter busy
grant_id  out  clog2(NUM_REQ)  index of current or last granted requester
active  out  1  high in SEND or GAP
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (arst=1, async) values:
  - tx_en=0, tx_rst=0, ack=0, tx_data=0
  - tx_load_value=DEFAULT_DIV, grant_id=NUM_REQ-1 (requester 0 has priority first)
  - active=0, timeout_err=0, FSM=IDLE, pending divisor cleared
- Reset mid-frame drops the frame silently: no ack.
- FSM states: IDLE, SEND, GAP; all outputs are registered.
- IDLE:
  - If any req bit is set, pick the first set bit searching from grant_id+1 upward, modulo NUM_REQ.
  - On that edge: latch tx_data from the winner's byte, update grant_id, set tx_en=1, clear the watchdog, go to SEND.
  - Latency: req sampled at edge N gives tx_en=1 after edge N.
- SEND:
  - tx_en stays 1 and tx_data stays frozen.
  - Changes to req or req_data are ignored.
  - On tx_done=1 at an edge: tx_en=0, ack[grant_id]=1 for one cycle, go to GAP.
  - Watchdog increments every SEND cycle. When it reaches all-ones with no tx_done: tx_en=0, tx_rst=1 for one cycle, ack[grant_id]=1, timeout_err=1, go to GAP.
  - If tx_done arrives in the same cycle as the watchdog expiry, tx_done wins: normal completion, no error.
- GAP:
  - The counter loads GAP_CYC on entry and decrements only while tx_busy=0.
  - At zero, go to IDLE.
  - tx_en=0 for at least GAP_CYC cycles, so the transmitter always sees a tx_en low phase between frames.
  - A requester acked in this frame may re-request immediately. It is arbitrated fairly: it is granted last if others are pending.
- Divisor:
  - cfg_div_we in IDLE: tx_load_value=cfg_div on the next edge.
  - cfg_div_we in SEND or GAP: value stored as pending and applied on the edge that enters IDLE.
  - The latest write wins; tx_load_value never changes during a frame.
- timeout_err:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr clears it next edge.
- At most one ack bit is high in any cycle; ack is never asserted in IDLE.
- active = (state != IDLE).

Test Plan:
- Reset then idle, no req → tx_en=0, tx_load_value=650, grant_id=3, ack=0; a cfg_div_we with 0x1A2 in IDLE gives tx_load_value=0x1A2 next cycle.
- req=0001, byte0=0x35, transmitter model asserts done 200 clocks later → tx_en=1 for 200 cycles with tx_data=0x35, ack=0001 one pulse, tx_en low ≥4 cycles, return to IDLE.
- req=1111 held, bytes 0xA0..0xA3, continuous re-request → grant order 0,1,2,3,0; each requester gets exactly one ack per frame.
- cfg_div_we=325 written mid-SEND → tx_load_value stays 650 until frame end, then 325 on the edge that enters IDLE.
- Transmitter model never asserts done (TO_W=8) → after 255 SEND cycles: tx_rst one pulse, ack pulse, timeout_err=1; err_clr clears it; the next request proceeds normally.
- arst asserted mid-SEND → tx_en=0 and FSM=IDLE immediately, no ack; after release, pending req=0100 is granted first-come (grant_id=2).

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter between byte requesters.
// Owns the baud divisor register and a frame watchdog with transmitter reset.
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int DIV_W       = 10,
    parameter int DEFAULT_DIV = 650,
    parameter int GAP_CYC     = 4,
    parameter int TO_W        = 16
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    input  logic [DIV_W-1:0]           cfg_div,
    input  logic                       cfg_div_we,
    input  logic                       err_clr,
    output logic                       tx_en,
    output logic [DATA_W-1:0]          tx_data,
    output logic [DIV_W-1:0]           tx_load_value,
    output logic                       tx_rst,
    input  logic                       tx_done,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t             state, state_nxt;
    logic               tx_en_nxt;
    logic [DATA_W-1:0]  tx_data_nxt;
    logic [DIV_W-1:0]   div_nxt;
    logic               tx_rst_nxt;
    logic [NUM_REQ-1:0] ack_nxt;
    logic [ID_W-1:0]    gid_nxt;
    logic               err_nxt;
    logic [TO_W-1:0]    wd, wd_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [DIV_W-1:0]   pend_div, pdiv_nxt;
    logic               pend_vld, pvld_nxt;
    logic               to_fire;

    // Search starts just after the last grant, so the last winner goes last.
    logic            found;
    logic [ID_W-1:0] win;
    int              idx;

    always_comb begin
        found = 1'b0;
        win   = grant_id;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(grant_id) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_en_nxt   = tx_en;
        tx_data_nxt = tx_data;
        div_nxt     = tx_load_value;
        tx_rst_nxt  = 1'b0;
        ack_nxt     = '0;
        gid_nxt     = grant_id;
        err_nxt     = timeout_err;
        wd_nxt      = wd;
        gap_nxt     = gap_cnt;
        pdiv_nxt    = pend_div;
        pvld_nxt    = pend_vld;
        to_fire     = 1'b0;

        unique case (state)
            IDLE: begin
                if (cfg_div_we) begin
                    div_nxt = cfg_div;
                end
                if (found) begin
                    tx_data_nxt = req_data[int'(win)*DATA_W +: DATA_W];
                    gid_nxt     = win;
                    tx_en_nxt   = 1'b1;
                    wd_nxt      = '0;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                if (cfg_div_we) begin
                    pdiv_nxt = cfg_div;
                    pvld_nxt = 1'b1;
                end
                if (tx_done) begin
                    tx_en_nxt         = 1'b0;
                    ack_nxt[grant_id] = 1'b1;
                    gap_nxt           = GAP_W'(GAP_CYC);
                    state_nxt         = GAP;
                end else if (wd == WD_LAST) begin
                    tx_en_nxt         = 1'b0;
                    tx_rst_nxt        = 1'b1;
                    ack_nxt[grant_id] = 1'b1;
                    to_fire           = 1'b1;
                    gap_nxt           = GAP_W'(GAP_CYC);
                    state_nxt         = GAP;
                end else begin
                    wd_nxt = wd + TO_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                    pvld_nxt  = 1'b0;
                    if (cfg_div_we) begin
                        div_nxt = cfg_div;
                    end else if (pend_vld) begin
                        div_nxt = pend_div;
                    end
                end else begin
                    if (cfg_div_we) begin
                        pdiv_nxt = cfg_div;
                        pvld_nxt = 1'b1;
                    end
                    if (!tx_busy) begin
                        gap_nxt = gap_cnt - GAP_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (to_fire) begin
            err_nxt = 1'b1;
        end else if (err_clr) begin
            err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state         <= IDLE;
            tx_en         <= 1'b0;
            tx_data       <= '0;
            tx_load_value <= DIV_W'(DEFAULT_DIV);
            tx_rst        <= 1'b0;
            ack           <= '0;
            grant_id      <= ID_W'(NUM_REQ - 1);
            timeout_err   <= 1'b0;
            active        <= 1'b0;
            wd            <= '0;
            gap_cnt       <= '0;
            pend_div      <= '0;
            pend_vld      <= 1'b0;
        end else begin
            state         <= state_nxt;
            tx_en         <= tx_en_nxt;
            tx_data       <= tx_data_nxt;
            tx_load_value <= div_nxt;
            tx_rst        <= tx_rst_nxt;
            ack           <= ack_nxt;
            grant_id      <= gid_nxt;
            timeout_err   <= err_nxt;
            active        <= (state_nxt != IDLE);
            wd            <= wd_nxt;
            gap_cnt       <= gap_nxt;
            pend_div      <= pdiv_nxt;
            pend_vld      <= pvld_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random requesters,
// compared each cycle against a frame-level scheduler model.
module tb_uart_tx_scheduler;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int VW    = 10;
    localparam int DEF   = 650;
    localparam int GAPC  = 4;
    localparam int TOW   = 8;
    localparam int WDMAX = (1 << TOW) - 1;

    logic            clk = 1'b0;
    logic            arst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic [VW-1:0]   cfg_div = '0;
    logic            cfg_div_we = 1'b0;
    logic            err_clr = 1'b0;
    logic            tx_en;
    logic [DW-1:0]   tx_data;
    logic [VW-1:0]   tx_load_value;
    logic            tx_rst;
    logic            tx_done = 1'b0;
    logic            tx_busy = 1'b0;
    logic [1:0]      grant_id;
    logic            active;
    logic            timeout_err;

    uart_tx_scheduler #(
        .NUM_REQ(N), .DATA_W(DW), .DIV_W(VW),
        .DEFAULT_DIV(DEF), .GAP_CYC(GAPC), .TO_W(TOW)
    ) dut (
        .clk(clk), .arst(arst), .req(req), .req_data(req_data),
        .ack(ack), .cfg_div(cfg_div), .cfg_div_we(cfg_div_we),
        .err_clr(err_clr), .tx_en(tx_en), .tx_data(tx_data),
        .tx_load_value(tx_load_value), .tx_rst(tx_rst),
        .tx_done(tx_done), .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_SEND, M_GAP} ph_t;

    int n_chk = 0;
    int n_pass = 0;

    ph_t     ph;
    int      last, exp_g, exp_len, en_len, rem;
    int      exp_div, pend;
    logic    exp_to, exp_err, ended, has_pend;
    logic [DW-1:0] exp_byte;
    int      grants[$];

    int      cur_lat = 10;
    int      cur_tail = 0;
    int      cnt = 0;
    int      tail_left = 0;
    bit      seen = 0;
    bit      rand_mode = 0;
    bit      rereq = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic reset_model();
        ph       = M_IDLE;
        last     = N - 1;
        exp_err  = 1'b0;
        exp_div  = DEF;
        has_pend = 1'b0;
        ended    = 1'b0;
        exp_to   = 1'b0;
    endtask

    // Inputs seen here are the ones sampled at the edge just gone.
    task automatic update_model();
        logic to_now;
        int   i;
        ended  = 1'b0;
        to_now = 1'b0;
        if (arst) begin
            reset_model();
            return;
        end
        case (ph)
            M_IDLE: begin
                if (cfg_div_we) exp_div = cfg_div;
                if (req != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        i = (last + k) % N;
                        if (req[i]) begin
                            exp_g = i;
                            break;
                        end
                    end
                    last     = exp_g;
                    exp_byte = req_data[exp_g*DW +: DW];
                    exp_to   = cur_lat > WDMAX;
                    exp_len  = exp_to ? WDMAX : cur_lat;
                    en_len   = 1;
                    ph       = M_SEND;
                    grants.push_back(exp_g);
                end
            end
            M_SEND: begin
                if (cfg_div_we) begin
                    pend     = cfg_div;
                    has_pend = 1'b1;
                end
                if (en_len == exp_len) begin
                    ended  = 1'b1;
                    to_now = exp_to;
                    rem    = GAPC + (exp_to ? 0 : cur_tail);
                    ph     = M_GAP;
                end else begin
                    en_len++;
                end
            end
            default: begin
                if (rem == 0) begin
                    ph = M_IDLE;
                    if (has_pend) exp_div = pend;
                    has_pend = 1'b0;
                    if (cfg_div_we) exp_div = cfg_div;
                end else begin
                    if (cfg_div_we) begin
                        pend     = cfg_div;
                        has_pend = 1'b1;
                    end
                    rem--;
                end
            end
        endcase
        if (to_now) exp_err = 1'b1;
        else if (err_clr) exp_err = 1'b0;
    endtask

    task automatic check_outputs();
        check("tx_en", tx_en, ph == M_SEND);
        check("active", active, ph != M_IDLE);
        check("ack", ack, ended ? (1 << exp_g) : 0);
        check("tx_rst", tx_rst, ended && exp_to);
        check("div", tx_load_value, exp_div);
        check("timeout_err", timeout_err, exp_err);
        check("grant_id", grant_id, last);
        if (ph == M_SEND) check("tx_data", tx_data, exp_byte);
    endtask

    // Transmitter stand-in: done after cur_lat cycles of tx_en,
    // busy lingers cur_tail cycles after tx_en drops.
    task automatic xmit();
        tx_done = 1'b0;
        if (arst || tx_rst) begin
            cnt = 0;
            seen = 0;
            tail_left = 0;
            tx_busy = 1'b0;
        end else if (tx_en) begin
            if (!seen) begin
                cnt++;
                if (cnt >= cur_lat) begin
                    tx_done = 1'b1;
                    seen = 1;
                    tail_left = cur_tail;
                end
            end
            tx_busy = 1'b1;
        end else begin
            cnt = 0;
            seen = 0;
            tx_busy = tail_left > 0;
            if (tail_left > 0) tail_left--;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        update_model();
        check_outputs();
        xmit();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            if (rand_mode) begin
                if ($urandom_range(0, 99) == 0) begin
                    cfg_div = VW'($urandom);
                    cfg_div_we = 1'b1;
                end
                err_clr = ($urandom_range(0, 49) == 0);
            end
            tick();
            cfg_div_we = 1'b0;
            if (rand_mode) err_clr = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if (rand_mode ? ($urandom_range(0, 3) != 0) : rereq) begin
                        req[i] = 1'b1;
                        if (rand_mode) req_data[i*DW +: DW] = DW'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (rand_mode && !req[i]
                             && $urandom_range(0, 7) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            if (rand_mode && ack != '0) begin
                cur_lat  = $urandom_range(1, 40);
                cur_tail = $urandom_range(0, 3);
            end
        end
    endtask

    initial begin
        reset_model();
        #1 arst = 1'b1;
        tick();
        tick();
        check("rst_data", tx_data, 0);
        arst = 1'b0;
        run(3);

        cfg_div = 10'h1A2;
        cfg_div_we = 1'b1;
        run(1);
        check("div_idle", tx_load_value, 10'h1A2);
        cfg_div = VW'(DEF);
        cfg_div_we = 1'b1;
        run(2);

        cur_lat = 200;
        req_data[0 +: DW] = 8'h35;
        req = 4'b0001;
        run(215);

        cur_lat = 100;
        req_data[DW +: DW] = 8'h5C;
        req = 4'b0010;
        run(50);
        cfg_div = 10'd325;
        cfg_div_we = 1'b1;
        run(1);
        run(60);
        check("div_after", tx_load_value, 325);

        arst = 1'b1;
        run(1);
        arst = 1'b0;
        grants.delete();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        cur_lat = 20;
        rereq = 1;
        req = 4'hF;
        run(110);
        rereq = 0;
        run(200);
        check("rr_cnt", grants.size() >= 5, 1);
        for (int k = 0; k < 5; k++) check("rr_order", grants[k], k % N);

        cur_lat = 100000;
        req = 4'b0100;
        run(270);
        err_clr = 1'b1;
        run(1);
        err_clr = 1'b0;
        run(2);

        req = 4'b1000;
        err_clr = 1'b1;
        run(270);
        err_clr = 1'b0;

        cur_lat = WDMAX;
        req = 4'b0001;
        run(270);

        cur_lat = 30;
        req = 4'b0010;
        run(45);

        cur_lat = 100;
        req = 4'b0001;
        run(20);
        req = 4'b0100;
        arst = 1'b1;
        #1;
        reset_model();
        check_outputs();
        check("arst_ack", ack, 0);
        run(1);
        arst = 1'b0;
        run(1);
        check("rst_grant", grant_id, 2);
        run(120);

        rand_mode = 1;
        cur_lat = 20;
        cur_tail = 1;
        run(6000);
        rand_mode = 0;
        rereq = 0;
        run(600);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
